gb_cpu_int_ctrl: RTL
====================

# gb_cpu_int_ctrl

Interrupt dispatch controller for the Game Boy CPU. It owns IME, EI delay and HALT wake-up. It sequences the 5 M-cycle interrupt service routine into the register file and memory write path: SP decrements, PC_H and PC_L pushes, and the PC load with the vector. The control unit stalls on `dispatch_busy`, and the controller's regfile write port is muxed ahead of the IDU port while busy.

## Interface
- No parameters.
- `clk` in 1: machine clock; one state per M-cycle.
- `reset` in 1: asynchronous, active-low.
- `fetch_boundary` in 1: final M-cycle of the current instruction; the next clock would begin an opcode fetch.
- `ie` in 5: IE register bits [4:0].
- `iflag` in 5: IF register bits [4:0].
- `ei` in 1: EI executed; pulse, coincident with its `fetch_boundary`.
- `di` in 1: DI executed; pulse.
- `reti` in 1: RETI executed; pulse.
- `halt_req` in 1: HALT executed; valid with `fetch_boundary`.
- `sp` in 16: current SP from the regfile.
- `pc` in 16: address of the next instruction.
- `dispatch_busy` out 1: high in every non-IDLE state.
- `ime` out 1: interrupt master enable.
- `halted` out 1: CPU halted; the control unit holds fetch.
- `idu_req` out `regfile_r16_t`: 16-bit regfile target.
- `idu_data` out 16: write data.
- `idu_wren` out 1: write enable.
- `mem_addr` out 16: bus address.
- `mem_wdata` out 8: bus write data.
- `mem_wr` out 1: bus write strobe.
- `if_ack` out 5: one-hot IF clear pulse.

## Operation
- Pending vector is `p = ie & iflag`. Priority: lowest bit wins. Vector address is 0x0040 + 8·n (0x40 VBlank, 0x48 STAT, 0x50 Timer, 0x58 Serial, 0x60 Joypad).
- FSM states: IDLE, WAIT, DEC_SP, PUSH_HI, PUSH_LO, JUMP.
- IDLE → WAIT when `fetch_boundary && ime && p != 0`. Entering WAIT clears `ime`.
- WAIT: no writes.
- DEC_SP: `idu_req`=REG_SP, `idu_data`=sp−1, `idu_wren`=1.
- PUSH_HI: `mem_addr`=sp, `mem_wdata`=pc[15:8], `mem_wr`=1. Also `idu_req`=REG_SP, `idu_data`=sp−1, `idu_wren`=1.
- PUSH_LO: `mem_addr`=sp, `mem_wdata`=pc[7:0], `mem_wr`=1. At the end of this cycle, re-sample `p` into the vector register. The PC_H push may have hit IE at 0xFFFF.
- JUMP: `idu_req`=REG_PC, `idu_data`=latched vector, `idu_wren`=1. `if_ack` is one-hot of the latched index. If the latched `p` was 0, the vector is 0x0000 and `if_ack`=0. Next state is IDLE.
- All write strobes and `if_ack` are Moore-decoded from the state and are 0 in IDLE and WAIT. Address and data outputs are 0 when their strobe is low.
- `sp` − 1 wraps modulo 2^16 (0x0000 → 0xFFFF).
- EI: an `ei` pulse sets `ei_pending`. At the next `fetch_boundary`, `ime` is set on the following clock. The dispatch check at that boundary uses the old `ime`=0.
- DI: clears `ime` and `ei_pending` on the next clock. If `di` and `ei` are asserted together, `di` wins.
- RETI: sets `ime` on the next clock, with no delay.
- HALT: `fetch_boundary && halt_req` sets `halted`.
- While `halted` and `p != 0`: `halted` clears on the next clock. If `ime`=1, the state goes to WAIT on that same clock; otherwise the CPU resumes with no dispatch. The wake condition is independent of `ime`.
- `halt_req` is ignored when `p != 0` at that boundary; `halted` stays 0.

## Timing
- Reset: state IDLE, `ime`=0, `ei_pending`=0, `halted`=0, vector register 0. Every output reads 0 and `idu_req` holds its 0-encoding.
- Reset asserted mid-dispatch forces IDLE asynchronously. Strobes drop in the same cycle, and a partial push is not completed.
- Dispatch takes 5 clocks, WAIT through JUMP. The first new opcode fetch is on the clock after JUMP.
- `dispatch_busy` is high for exactly 5 clocks.
- A `fetch_boundary` while busy is ignored.
- `ei`, `di`, `reti` and `halt_req` are ignored while busy.
- `if_ack` is high for 1 clock, in JUMP only.

## Structure
- `gb_cpu_common_pkg` gains:
  - `int_state_t` enum.
  - `INT_VEC_BASE` = 16'h0040 and `INT_VEC_STRIDE` = 8.
  - `int_src_t` index enum.
- Sub-module `gb_cpu_int_prio`: combinational priority encoder. Input is 5-bit `p`; outputs are `any`, 3-bit index, one-hot and 16-bit vector. It is instantiated once.
- The FSM, IME/EI logic and HALT logic live in `gb_cpu_int_ctrl`.

## Test plan
- ime=1, ie=0x1F, iflag=0x05, sp=0xFFFE, pc=0x1234, pulse `fetch_boundary` → writes 0x12@0xFFFD and 0x34@0xFFFC; SP ends at 0xFFFC; PC=0x0040; `if_ack`=0x01; `ime`=0; busy for 5 clocks.
- Same stimulus with sp=0x0000 → SP writes 0xFFFF then 0xFFFE; `mem_addr` sequence 0xFFFF, 0xFFFE.
- During PUSH_HI drive ie to 0x00 → JUMP writes PC=0x0000 and `if_ack`=0.
- `ei` at boundary N with iflag&ie=0x04 → no dispatch at N; `ime`=1 after N+1; dispatch starts at boundary N+2 with vector 0x50. Also check `ei`+`di` together → `ime` stays 0.
- `halt_req` with p=0, then set iflag=0x10 with ime=0 → `halted` falls 1 clock later and no writes occur. Repeat with ime=1 → WAIT entered and PC=0x0060.
- Assert `reset` low during PUSH_LO → `mem_wr` falls immediately, state IDLE, `ime`=0; a later dispatch completes normally.

Source files
------------

// File: rtl/gb_cpu_common_pkg.sv
// Shared types for the Game Boy CPU core.
// Register file targets, interrupt FSM states and vector constants.
package gb_cpu_common_pkg;

   typedef enum logic [2:0] {
      REG_NONE = 3'd0,
      REG_AF   = 3'd1,
      REG_BC   = 3'd2,
      REG_DE   = 3'd3,
      REG_HL   = 3'd4,
      REG_SP   = 3'd5,
      REG_PC   = 3'd6
   } regfile_r16_t;

   typedef enum logic [2:0] {
      INT_IDLE    = 3'd0,
      INT_WAIT    = 3'd1,
      INT_DEC_SP  = 3'd2,
      INT_PUSH_HI = 3'd3,
      INT_PUSH_LO = 3'd4,
      INT_JUMP    = 3'd5
   } int_state_t;

   typedef enum logic [2:0] {
      INT_VBLANK = 3'd0,
      INT_STAT   = 3'd1,
      INT_TIMER  = 3'd2,
      INT_SERIAL = 3'd3,
      INT_JOYPAD = 3'd4
   } int_src_t;

   localparam logic [15:0] INT_VEC_BASE   = 16'h0040;
   localparam logic [15:0] INT_VEC_STRIDE = 16'd8;

   function automatic logic [15:0] int_vector(int_src_t s);
      return INT_VEC_BASE + INT_VEC_STRIDE * 16'(s);
   endfunction

endpackage

// File: rtl/gb_cpu_int_prio.sv
// Interrupt priority encoder: lowest pending bit wins.
// Produces index, one-hot and vector address for the winner.
module gb_cpu_int_prio
   import gb_cpu_common_pkg::*;
(
   input  logic [4:0]  p_i,
   output logic        any_o,
   output logic [2:0]  idx_o,
   output logic [4:0]  onehot_o,
   output logic [15:0] vec_o
);

   always_comb begin
      idx_o = 3'd0;
      for (int i = 4; i >= 0; i--) begin
         if (p_i[i]) idx_o = 3'(i);
      end
      any_o    = |p_i;
      onehot_o = any_o ? (5'd1 << idx_o) : 5'd0;
      vec_o    = any_o ? int_vector(int_src_t'(idx_o)) : 16'h0000;
   end

endmodule

// File: rtl/gb_cpu_int_ctrl.sv
// Interrupt dispatch controller: IME, EI delay, HALT wake and
// the 5 M-cycle push/jump sequence into regfile and memory.
module gb_cpu_int_ctrl
   import gb_cpu_common_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         fetch_boundary,
   input  logic [4:0]   ie,
   input  logic [4:0]   iflag,
   input  logic         ei,
   input  logic         di,
   input  logic         reti,
   input  logic         halt_req,
   input  logic [15:0]  sp,
   input  logic [15:0]  pc,
   output logic         dispatch_busy,
   output logic         ime,
   output logic         halted,
   output regfile_r16_t idu_req,
   output logic [15:0]  idu_data,
   output logic         idu_wren,
   output logic [15:0]  mem_addr,
   output logic [7:0]   mem_wdata,
   output logic         mem_wr,
   output logic [4:0]   if_ack
);

   int_state_t  state_q, state_d;
   logic        ime_q, ime_d;
   logic        eip_q, eip_d;
   logic        halted_q, halted_d;
   logic [4:0]  pq_q, pq_d;

   logic [4:0]  p;
   logic [4:0]  prio_p;
   logic        pr_any;
   logic [2:0]  unused_idx;
   logic [4:0]  pr_oh;
   logic [15:0] pr_vec;
   logic [15:0] sp_m1;

   assign p      = ie & iflag;
   assign sp_m1  = sp - 16'd1;
   // JUMP decodes the latched pending set, every other state the live one
   assign prio_p = (state_q == INT_JUMP) ? pq_q : p;

   gb_cpu_int_prio u_prio (
      .p_i      (prio_p),
      .any_o    (pr_any),
      .idx_o    (unused_idx),
      .onehot_o (pr_oh),
      .vec_o    (pr_vec)
   );

   always_comb begin
      state_d  = state_q;
      ime_d    = ime_q;
      eip_d    = eip_q;
      halted_d = halted_q;
      pq_d     = pq_q;
      unique case (state_q)
         INT_IDLE: begin
            if (halted_q) begin
               if (pr_any) begin
                  halted_d = 1'b0;
                  if (ime_q) begin
                     state_d = INT_WAIT;
                     ime_d   = 1'b0;
                     pq_d    = p;
                  end
               end
            end else begin
               if (reti) ime_d = 1'b1;
               if (fetch_boundary && eip_q) begin
                  ime_d = 1'b1;
                  eip_d = 1'b0;
               end
               if (ei) eip_d = 1'b1;
               if (di) begin
                  ime_d = 1'b0;
                  eip_d = 1'b0;
               end
               if (fetch_boundary && halt_req && !pr_any)
                  halted_d = 1'b1;
               // dispatch test sees the pre-update IME
               if (fetch_boundary && ime_q && pr_any) begin
                  state_d = INT_WAIT;
                  ime_d   = 1'b0;
                  pq_d    = p;
               end
            end
         end
         INT_WAIT:    state_d = INT_DEC_SP;
         INT_DEC_SP:  state_d = INT_PUSH_HI;
         INT_PUSH_HI: state_d = INT_PUSH_LO;
         INT_PUSH_LO: begin
            // PC_H push may have rewritten IE at 0xFFFF
            state_d = INT_JUMP;
            pq_d    = p;
         end
         INT_JUMP:    state_d = INT_IDLE;
         default:     state_d = INT_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= INT_IDLE;
         ime_q    <= 1'b0;
         eip_q    <= 1'b0;
         halted_q <= 1'b0;
         pq_q     <= 5'd0;
      end else begin
         state_q  <= state_d;
         ime_q    <= ime_d;
         eip_q    <= eip_d;
         halted_q <= halted_d;
         pq_q     <= pq_d;
      end
   end

   always_comb begin
      idu_req   = REG_NONE;
      idu_data  = 16'h0000;
      idu_wren  = 1'b0;
      mem_addr  = 16'h0000;
      mem_wdata = 8'h00;
      mem_wr    = 1'b0;
      if_ack    = 5'd0;
      unique case (state_q)
         INT_DEC_SP: begin
            idu_req  = REG_SP;
            idu_data = sp_m1;
            idu_wren = 1'b1;
         end
         INT_PUSH_HI: begin
            mem_addr  = sp;
            mem_wdata = pc[15:8];
            mem_wr    = 1'b1;
            idu_req   = REG_SP;
            idu_data  = sp_m1;
            idu_wren  = 1'b1;
         end
         INT_PUSH_LO: begin
            mem_addr  = sp;
            mem_wdata = pc[7:0];
            mem_wr    = 1'b1;
         end
         INT_JUMP: begin
            idu_req  = REG_PC;
            idu_data = pr_vec;
            idu_wren = 1'b1;
            if_ack   = pr_oh;
         end
         default: ;
      endcase
   end

   assign dispatch_busy = (state_q != INT_IDLE);
   assign ime           = ime_q;
   assign halted        = halted_q;

endmodule
